// File: rtl/mips32_pkg.sv
// Shared opcodes, ALU function codes and pipeline register payloads for mips32_core.
package mips32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [1:0] OP_IPFX  = 2'b01;
  localparam logic [5:0] OP_LW    = 6'b110000;
  localparam logic [5:0] OP_SW    = 6'b110001;
  localparam logic [5:0] OP_BEQZ  = 6'b110100;
  localparam logic [5:0] OP_BNEZ  = 6'b110101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_MUL = 4'd2;
  localparam logic [3:0] FN_AND = 4'd3;
  localparam logic [3:0] FN_OR  = 4'd4;
  localparam logic [3:0] FN_XOR = 4'd5;
  localparam logic [3:0] FN_SLT = 4'd6;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [3:0]  fn;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] val_a;
    logic [31:0] target;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        br;
    logic        br_nz;
  } idex_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] alu;
    logic [31:0] store;
  } exmem_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] wdata;
  } memwb_t;

  localparam ifid_t IFID_NOP = '{pc: 32'h0, instr: NOP_WORD};

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU shared by R-type, I-type and address generation.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [3:0]  i_fn,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res_c
);

  always_comb begin
    o_res_c = i_a + i_b;
    case (i_fn)
      FN_SUB:  o_res_c = i_a - i_b;
      FN_MUL:  o_res_c = i_a * i_b;
      FN_AND:  o_res_c = i_a & i_b;
      FN_OR:   o_res_c = i_a | i_b;
      FN_XOR:  o_res_c = i_a ^ i_b;
      FN_SLT:  o_res_c = {31'b0, ($signed(i_a) < $signed(i_b))};
      default: ;
    endcase
  end

endmodule

// File: rtl/mips32_id.sv
// Decode stage: register file (written from WB), decoder and the ID/EX register.
module mips32_id
  import mips32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  ifid_t       i_ifid,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output idex_t       o_idex,
  output logic        o_hlt_c
);

  logic [31:0] reg_b [0:31] = '{default: '0};
  idex_t       r_idex = '0;
  idex_t       w_dec;
  logic [5:0]  w_op;
  logic [4:0]  w_a, w_b, w_c;
  logic [31:0] w_imm;
  logic        w_unused;

  assign w_op     = i_ifid.instr[31:26];
  assign w_a      = i_ifid.instr[25:21];
  assign w_b      = i_ifid.instr[20:16];
  assign w_c      = i_ifid.instr[15:11];
  assign w_imm    = {{16{i_ifid.instr[15]}}, i_ifid.instr[15:0]};
  assign o_hlt_c  = (w_op == OP_HLT);
  assign w_unused = ^i_ifid.instr[10:4];

  // reg_b[0] is never written, so it always reads as zero.
  always_comb begin
    w_dec        = '0;
    w_dec.rd     = w_a;
    w_dec.fn     = FN_ADD;
    w_dec.opa    = reg_b[w_b];
    w_dec.opb    = w_imm;
    w_dec.val_a  = reg_b[w_a];
    w_dec.target = i_ifid.pc + 32'd1 + w_imm;
    if (w_op == OP_RTYPE) begin
      w_dec.reg_we = 1'b1;
      w_dec.fn     = i_ifid.instr[3:0];
      w_dec.opb    = reg_b[w_c];
    end else if (w_op[5:4] == OP_IPFX) begin
      w_dec.reg_we = 1'b1;
      w_dec.fn     = w_op[3:0];
    end else begin
      case (w_op)
        OP_LW: begin
          w_dec.reg_we = 1'b1;
          w_dec.mem_rd = 1'b1;
        end
        OP_SW:   w_dec.mem_wr = 1'b1;
        OP_BEQZ: w_dec.br     = 1'b1;
        OP_BNEZ: begin
          w_dec.br    = 1'b1;
          w_dec.br_nz = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) r_idex <= '0;
    else                  r_idex <= w_dec;
  end

  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != 5'd0)) reg_b[i_waddr] <= i_wdata;
  end

  assign o_idex = r_idex;

endmodule

// File: rtl/mips32_if.sv
// Fetch stage: program counter, instruction memory and the IF/ID register.
module mips32_if
  import mips32_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned RESET_PC   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic        i_stall,
  input  logic [31:0] i_target,
  output ifid_t       o_ifid
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);

  logic [31:0] mem [0:IMEM_DEPTH-1] = '{default: '0};
  logic [31:0] r_pc   = 32'(RESET_PC);
  ifid_t       r_ifid = IFID_NOP;

  // A taken branch outranks a halt stall; both insert a bubble into IF/ID.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc   <= 32'(RESET_PC);
      r_ifid <= IFID_NOP;
    end else if (i_redirect) begin
      r_pc   <= i_target;
      r_ifid <= IFID_NOP;
    end else if (i_stall) begin
      r_ifid <= IFID_NOP;
    end else begin
      r_ifid <= '{pc: r_pc, instr: mem[r_pc[IAW-1:0]]};
      r_pc   <= r_pc + 32'd1;
    end
  end

  assign o_ifid = r_ifid;

endmodule

// File: rtl/mips32_mem.sv
// Memory stage: data memory and the MEM/WB register.
module mips32_mem
  import mips32_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 1024
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  exmem_t i_exmem,
  output memwb_t o_memwb
);

  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  logic [31:0]    data [0:DMEM_DEPTH-1] = '{default: '0};
  memwb_t         r_memwb = '0;
  logic [DAW-1:0] w_addr;

  assign w_addr = i_exmem.alu[DAW-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_exmem.mem_wr) data[w_addr] <= i_exmem.store;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_memwb <= '0;
    else       r_memwb <= '{rd:     i_exmem.rd,
                            reg_we: i_exmem.reg_we,
                            wdata:  i_exmem.mem_rd ? data[w_addr] : i_exmem.alu};
  end

  assign o_memwb = r_memwb;

endmodule

// File: rtl/mips32_core.sv
// 5-stage in-order MIPS32-style pipeline without forwarding or interlocks.
module mips32_core
  import mips32_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned RESET_PC   = 1
) (
  input logic clk_x,
  input logic rst
);

  ifid_t       w_ifid;
  idex_t       w_idex;
  memwb_t      w_memwb;
  exmem_t      r_exmem  = '0;
  logic        r_halted = 1'b0;
  logic        w_id_hlt, w_br_taken, w_halt_now, w_wb_we;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_alu, w_wb_data;

  // Branch resolves in EX and squashes a HLT sitting in ID.
  assign w_br_taken = w_idex.br & (w_idex.br_nz ? (w_idex.val_a != 32'd0) : (w_idex.val_a == 32'd0));
  assign w_halt_now = r_halted | (w_id_hlt & ~w_br_taken);
  assign w_wb_we    = w_memwb.reg_we & ~rst;
  assign w_wb_rd    = w_memwb.rd;
  assign w_wb_data  = w_memwb.wdata;

  mips32_if #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(RESET_PC)) i_f (
    .i_clk(clk_x), .i_rst(rst), .i_redirect(w_br_taken), .i_stall(w_halt_now),
    .i_target(w_idex.target), .o_ifid(w_ifid)
  );

  mips32_id id (
    .i_clk(clk_x), .i_rst(rst), .i_flush(w_br_taken), .i_ifid(w_ifid),
    .i_we(w_wb_we), .i_waddr(w_wb_rd), .i_wdata(w_wb_data),
    .o_idex(w_idex), .o_hlt_c(w_id_hlt)
  );

  mips32_alu u_alu (
    .i_fn(w_idex.fn), .i_a(w_idex.opa), .i_b(w_idex.opb), .o_res_c(w_alu)
  );

  mips32_mem #(.DMEM_DEPTH(DMEM_DEPTH)) max (
    .i_clk(clk_x), .i_rst(rst), .i_exmem(r_exmem), .o_memwb(w_memwb)
  );

  always_ff @(posedge clk_x) begin
    if (rst) begin
      r_exmem  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_exmem <= '{rd: w_idex.rd, reg_we: w_idex.reg_we, mem_rd: w_idex.mem_rd,
                   mem_wr: w_idex.mem_wr, alu: w_alu, store: w_idex.val_a};
      if (w_id_hlt && !w_br_taken) r_halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips32_core.sv
// Directed program bench: register writebacks are checked against a queue of expected writes.
module tb_mips32_core;

  logic clk_x = 1'b0;
  logic rst   = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk_x = ~clk_x;

  mips32_core dut (.clk_x(clk_x), .rst(rst));

  function automatic logic [31:0] f_r(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [3:0] fn);
    return {6'b0, a, b, c, 7'b0, fn};
  endfunction

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val);
    wr_t e;
    e.rd  = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (dut.r_halted === 1'b1) break;
      @(negedge clk_x);
    end
    chk(tag, {31'b0, dut.r_halted}, 32'd1);
    repeat (6) @(negedge clk_x);
  endtask

  // Every non-R0 writeback must match the oldest outstanding expectation.
  always @(negedge clk_x) begin
    if (dut.w_wb_we === 1'b1 && dut.w_wb_rd !== 5'd0) begin
      wr_t e;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL wb_unexpected observed=R%0d<=%h expected=no write", dut.w_wb_rd, dut.w_wb_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({dut.w_wb_rd, dut.w_wb_data} === {e.rd, e.val}) else begin
          bad++;
          $error("FAIL wb observed=R%0d<=%h expected=R%0d<=%h", dut.w_wb_rd, dut.w_wb_data, e.rd, e.val);
        end
      end
    end
  end

  task automatic load_prog1();
    for (int i = 0; i < 64; i++) dut.i_f.mem[i] = 32'h0;
    dut.max.data[1] = 32'h5;
    dut.max.data[2] = 32'h7;
    dut.i_f.mem[1]  = 32'hC020_0001;
    dut.i_f.mem[2]  = 32'hC040_0002;
    dut.i_f.mem[7]  = 32'h0061_1000;
    dut.i_f.mem[12] = 32'h4883_0002;
    dut.i_f.mem[17] = 32'hC480_0003;
    dut.i_f.mem[21] = 32'hD000_0005;
    for (int i = 22; i <= 26; i++) dut.i_f.mem[i] = f_i(6'b010000, 5'd5, 5'd0, 16'd1);
    dut.i_f.mem[27] = 32'hFFFF_0005;
    dut.i_f.mem[28] = f_i(6'b010000, 5'd5, 5'd0, 16'd9);
  endtask

  task automatic expect_prog1();
    push(5'd1, 32'h5);
    push(5'd2, 32'h7);
    push(5'd3, 32'hC);
    push(5'd4, 32'h18);
  endtask

  task automatic check_prog1(input string tag);
    chk({tag, "_r1"}, dut.id.reg_b[1], 32'h5);
    chk({tag, "_r2"}, dut.id.reg_b[2], 32'h7);
    chk({tag, "_r3"}, dut.id.reg_b[3], 32'hC);
    chk({tag, "_r4"}, dut.id.reg_b[4], 32'h18);
    chk({tag, "_d3"}, dut.max.data[3], 32'h18);
    chk({tag, "_r5"}, dut.id.reg_b[5], 32'h0);
    chk({tag, "_pc"}, dut.i_f.r_pc, 32'd28);
    chk({tag, "_q"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    chk("pwr_pc", dut.i_f.r_pc, 32'd1);
    chk("pwr_halt", {31'b0, dut.r_halted}, 32'd0);
    chk("pwr_ifid", dut.w_ifid.instr, 32'h0);
    chk("pwr_r9", dut.id.reg_b[9], 32'h0);

    // Program 1 from power-up: loads, ADD, MULI, SW, BEQZ squash/skip, HLT.
    load_prog1();
    expect_prog1();
    @(negedge clk_x);
    wait_halt("p1_halt");
    check_prog1("p1");
    repeat (10) @(negedge clk_x);
    chk("p1_pc_frozen", dut.i_f.r_pc, 32'd28);
    chk("p1_r5_still", dut.id.reg_b[5], 32'h0);

    // One-cycle reset after halt: fetch restarts, state survives.
    rst = 1'b1;
    @(negedge clk_x);
    rst = 1'b0;
    chk("rst_pc", dut.i_f.r_pc, 32'd1);
    chk("rst_halt", {31'b0, dut.r_halted}, 32'd0);
    chk("rst_ifid", dut.w_ifid.instr, 32'h0);
    chk("rst_r4_kept", dut.id.reg_b[4], 32'h18);
    chk("rst_d3_kept", dut.max.data[3], 32'h18);
    expect_prog1();
    wait_halt("p1b_halt");
    check_prog1("p1b");

    // Program 2: SUB/SLT, R0 write, BNEZ taken/not-taken, I-type logic ops.
    rst = 1'b1;
    for (int i = 0; i < 64; i++) dut.i_f.mem[i] = 32'h0;
    dut.i_f.mem[1]  = f_i(6'b010000, 5'd1, 5'd0, 16'd3);
    dut.i_f.mem[2]  = f_i(6'b010000, 5'd2, 5'd0, 16'd5);
    dut.i_f.mem[7]  = f_r(5'd6, 5'd1, 5'd2, 4'd1);
    dut.i_f.mem[8]  = f_r(5'd7, 5'd1, 5'd2, 4'd6);
    dut.i_f.mem[9]  = f_r(5'd0, 5'd1, 5'd2, 4'd0);
    dut.i_f.mem[10] = f_i(6'b110101, 5'd1, 5'd0, 16'd2);
    dut.i_f.mem[11] = f_i(6'b010000, 5'd8, 5'd0, 16'd1);
    dut.i_f.mem[12] = f_i(6'b010000, 5'd8, 5'd0, 16'd2);
    dut.i_f.mem[13] = f_i(6'b110101, 5'd0, 5'd0, 16'd2);
    dut.i_f.mem[14] = f_i(6'b010000, 5'd9, 5'd0, 16'h11);
    dut.i_f.mem[15] = f_i(6'b010100, 5'd12, 5'd1, 16'h8);
    dut.i_f.mem[16] = f_i(6'b010101, 5'd13, 5'd2, 16'hF);
    dut.i_f.mem[17] = f_i(6'b010011, 5'd14, 5'd2, 16'h6);
    dut.i_f.mem[18] = f_i(6'b010000, 5'd15, 5'd1, 16'hFFFF);
    dut.i_f.mem[19] = f_i(6'b111111, 5'd0, 5'd0, 16'd0);
    dut.i_f.mem[20] = f_i(6'b010000, 5'd11, 5'd0, 16'd1);
    repeat (2) @(negedge clk_x);
    rst = 1'b0;
    push(5'd1, 32'h3);
    push(5'd2, 32'h5);
    push(5'd6, 32'hFFFF_FFFE);
    push(5'd7, 32'h1);
    push(5'd9, 32'h11);
    push(5'd12, 32'hB);
    push(5'd13, 32'hA);
    push(5'd14, 32'h4);
    push(5'd15, 32'h2);
    wait_halt("p2_halt");
    chk("p2_sub", dut.id.reg_b[6], 32'hFFFF_FFFE);
    chk("p2_slt", dut.id.reg_b[7], 32'h1);
    chk("p2_r0", dut.id.reg_b[0], 32'h0);
    chk("p2_bnez_skip", dut.id.reg_b[8], 32'h0);
    chk("p2_bnez_fall", dut.id.reg_b[9], 32'h11);
    chk("p2_after_hlt", dut.id.reg_b[11], 32'h0);
    chk("p2_pc", dut.i_f.r_pc, 32'd20);
    chk("p2_q", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips32_core.md
Name: mips32_core

Overview:
- 5-stage in-order pipelined MIPS32-style CPU: IF, ID, EX, MEM, WB.
- 32-bit datapath, word-addressed instruction and data memories.
- No forwarding and no interlocks; software separates dependent instructions with 4 NOPs.
- Top-level CPU block; the bench preloads memories and inspects state hierarchically.

Parameters:
- IMEM_DEPTH, 1024, instruction memory words.
- DMEM_DEPTH, 1024, data memory words.
- RESET_PC, 1, first fetch address after power-up or reset (word 0 is reserved).

Ports:
- clk_x  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Required hierarchy:
  - instance i_f holds array mem[0:IMEM_DEPTH-1] (32-bit).
  - instance id holds array reg_b[0:31] (32-bit register file).
  - instance max holds array data[0:DMEM_DEPTH-1] (32-bit).
- Power-up state (declaration init, since rst may never assert before running): PC=RESET_PC, pipeline registers hold NOP (0x00000000), reg_b all zero, halted=0.
- Reset: PC<=RESET_PC, all pipeline registers <=NOP, halted<=0. reg_b, mem and data are NOT cleared. Reset mid-program restarts execution from RESET_PC on the next cycle.
- Encoding: op=[31:26], A=[25:20:21 field, i.e. bits 25:21], B=[20:16], C=[15:11], imm=[15:0] sign-extended, fn=[3:0].
- R-type (op 000000): reg[A] <= reg[B] fn reg[C].
  - fn: 0 ADD, 1 SUB, 2 MUL (low 32 bits), 3 AND, 4 OR, 5 XOR, 6 SLT (signed, result 0/1).
  - Other fn values execute as ADD.
- I-type ALU (op 01xxxx): reg[A] <= reg[B] op imm, where op=[29:26] uses the fn table above (e.g. 010010 = MULI).
- LW 110000: reg[A] <= data[reg[B]+imm].
- SW 110001: data[reg[B]+imm] <= reg[A].
- Memory addresses are taken modulo DMEM_DEPTH (low log2 bits).
- BEQZ 110100: taken if reg[A]==0. BNEZ 110101: taken if reg[A]!=0.
  - Target = branch PC + 1 + imm.
  - Resolved in EX: on a taken branch, PC<=target and the IF/ID and ID/EX registers are loaded with NOP (2-instruction squash).
- HLT 111111: when it reaches ID and is not being squashed, halted<=1.
  - While halted, PC is frozen and IF/ID receives NOP; older instructions drain to completion.
  - Only rst clears halted.
- Any other opcode is a NOP.
- Writes to reg_b[0] are ignored; reg_b[0] reads as 0.
- Instruction 0x00000000 is a true NOP (ADD R0).
- Register file is written in WB and read in ID. No bypass is required given the 4-NOP rule.
- Instruction fetch address is taken modulo IMEM_DEPTH.
- Latency: an instruction fetched at cycle n writes reg_b at the edge ending cycle n+4. A store updates data at the edge ending cycle n+3.
- Simultaneous taken branch (EX) and HLT (ID): the branch wins and the HLT is squashed.

Decomposition:
- Package mips32_pkg:
  - opcode constants (R-type, I-type prefix, LW, SW, BEQZ, BNEZ, HLT).
  - fn/ALU op constants.
  - NOP word constant.
  - pipeline register struct typedefs.
- One natural sub-module: mips32_alu (combinational, op code plus two 32-bit operands -> 32-bit result).
- Stage instances i_f, id and max as required above.

Test Plan:
- Preload data[1]=0x00000005, data[2]=0x00000007. Program:
  - mem[1]=0xC0200001, mem[2]=0xC0400002, 4 NOPs.
  - mem[7]=0x00611000, 4 NOPs.
  - mem[12]=0x48830002, 4 NOPs.
  - mem[17]=0xC4800003.
  - Required after 35 cycles: R1=5, R2=7, R3=0xC, R4=0x18, data[3]=0x18.
- Same program with mem[21]=0xD0000005 and mem[27]=0xFFFF0005, mem[22..26] filled with ADDI R5,R0,1 -> R5 stays 0, halt reached, PC frozen at 28, no further writes.
- BNEZ on R1=5 with imm=2 -> skips 2 instructions; BNEZ on R0 -> falls through.
- SUB/SLT: R1=3, R2=5 -> SUB gives 0xFFFFFFFE, SLT gives 1. Write to R0 -> R0 remains 0.
- Assert rst for 1 cycle after halt -> halted clears, fetch restarts at address 1, reg_b and data contents are preserved.
